// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: shared types and constants for the UART ALU host sequencer.
package alu_uart_pkg;

    localparam int DATA_W      = 8;
    localparam int OPCODE_W    = 6;
    localparam int FRAME_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_TX,
        WAIT_RX,
        DONE
    } state_t;

    // Wire order of a command frame: A, B, then the zero-padded opcode.
    function automatic logic [DATA_W-1:0] frame_byte(
        input logic [DATA_W-1:0]   a,
        input logic [DATA_W-1:0]   b,
        input logic [OPCODE_W-1:0] op,
        input logic [1:0]          idx
    );
        return idx == 2'd0 ? a :
               idx == 2'd1 ? b :
               {{(DATA_W-OPCODE_W){1'b0}}, op};
    endfunction

endpackage

// File: rtl/alu_uart_host_if.sv
// alu_uart_host_if: request, result and UART byte-port signals of the host sequencer.
interface alu_uart_host_if;
    import alu_uart_pkg::*;

    logic                i_req;
    logic [DATA_W-1:0]   i_op_a;
    logic [DATA_W-1:0]   i_op_b;
    logic [OPCODE_W-1:0] i_opcode;
    logic                o_busy;
    logic                o_tx_start;
    logic [DATA_W-1:0]   o_tx_data;
    logic                i_tx_done;
    logic                i_rx_done;
    logic [DATA_W-1:0]   i_rx_data;
    logic [DATA_W-1:0]   o_result;
    logic                o_valid;
    logic                o_timeout;

    modport master (
        input  i_req, i_op_a, i_op_b, i_opcode, i_tx_done, i_rx_done, i_rx_data,
        output o_busy, o_tx_start, o_tx_data, o_result, o_valid, o_timeout
    );

    modport slave (
        output i_req, i_op_a, i_op_b, i_opcode, i_tx_done, i_rx_done, i_rx_data,
        input  o_busy, o_tx_start, o_tx_data, o_result, o_valid, o_timeout
    );

endinterface

// File: rtl/alu_uart_host.sv
// alu_uart_host: sends a 3-byte ALU command over a UART transmitter and waits,
// with a timeout, for the 1-byte result from a UART receiver.
module alu_uart_host
    import alu_uart_pkg::*;
#(
    parameter int RESP_TIMEOUT = 2_000_000
) (
    input logic             i_clk,
    input logic             i_reset,
    alu_uart_host_if.master bus
);

    localparam int             CNT_W    = $clog2(RESP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);
    localparam logic [1:0]     LAST_IDX = 2'(FRAME_BYTES - 1);

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                busy_q, busy_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.i_req ? START : IDLE;
            START:   state_d = WAIT_TX;
            WAIT_TX: state_d = !bus.i_tx_done ? WAIT_TX : idx_q == LAST_IDX ? WAIT_RX : START;
            WAIT_RX: state_d = bus.i_rx_done ? DONE : cnt_q == CNT_LAST ? IDLE : WAIT_RX;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so each is computed from the state being entered.
    always_comb begin
        a_d        = (state_q == IDLE && bus.i_req) ? bus.i_op_a : a_q;
        b_d        = (state_q == IDLE && bus.i_req) ? bus.i_op_b : b_q;
        op_d       = (state_q == IDLE && bus.i_req) ? bus.i_opcode : op_q;
        idx_d      = state_q == IDLE ? 2'd0 :
                     (state_q == WAIT_TX && bus.i_tx_done && idx_q != LAST_IDX) ? idx_q + 2'd1 : idx_q;
        cnt_d      = state_q == WAIT_RX ? cnt_q + CNT_W'(1) : '0;
        busy_d     = state_d != IDLE;
        tx_start_d = state_d == START;
        tx_data_d  = state_d == START ? frame_byte(a_d, b_d, op_d, idx_d) : tx_data_q;
        result_d   = (state_q == WAIT_RX && bus.i_rx_done) ? bus.i_rx_data : result_q;
        valid_d    = state_d == DONE;
        timeout_d  = state_q == WAIT_RX && !bus.i_rx_done && cnt_q == CNT_LAST;
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_result   = result_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_timeout  = timeout_q;

endmodule

// File: tb/tb_alu_uart_host.sv
// tb_alu_uart_host: directed self-checking bench for the UART ALU host sequencer.
module tb_alu_uart_host;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    logic [7:0] txq[$];

    alu_uart_host_if bus();

    alu_uart_host #(.RESP_TIMEOUT(50)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.o_tx_start) txq.push_back(bus.o_tx_data);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic start_req(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op, input string tag);
        bus.i_req    = 1'b1;
        bus.i_op_a   = a;
        bus.i_op_b   = b;
        bus.i_opcode = op;
        @(negedge clk);
        bus.i_req = 1'b0;
        check({tag, "_req2start"}, bus.o_tx_start, 1);
        check({tag, "_busy"}, bus.o_busy, 1);
    endtask

    // Transmitter model: 10 cycles after the start pulse, one tx_done pulse.
    task automatic tx_byte(input logic [7:0] exp, input bit last, input bit stray, input string tag);
        int i;
        i = 0;
        while (!bus.o_tx_start && i < 100) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_start"}, bus.o_tx_start, 1);
        check({tag, "_data"}, bus.o_tx_data, exp);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (stray && k == 4) begin
                bus.i_rx_done = 1'b1;
                bus.i_rx_data = 8'h55;
                bus.i_req     = 1'b1;
                bus.i_op_a    = 8'h99;
            end else begin
                bus.i_rx_done = 1'b0;
                bus.i_req     = 1'b0;
            end
        end
        check({tag, "_held"}, bus.o_tx_data, exp);
        check({tag, "_onepulse"}, bus.o_tx_start, 0);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        check({tag, "_gap"}, bus.o_tx_start, {31'd0, !last});
    endtask

    task automatic rx_resp(input logic [7:0] d, input string tag);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = d;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        check({tag, "_valid"}, bus.o_valid, 1);
        check({tag, "_result"}, bus.o_result, d);
        check({tag, "_busy_done"}, bus.o_busy, 1);
        @(negedge clk);
        check({tag, "_valid_off"}, bus.o_valid, 0);
        check({tag, "_idle"}, bus.o_busy, 0);
        check({tag, "_hold"}, bus.o_result, d);
    endtask

    initial begin
        bit early;
        n_chk         = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.i_req     = 1'b0;
        bus.i_op_a    = '0;
        bus.i_op_b    = '0;
        bus.i_opcode  = '0;
        bus.i_tx_done = 1'b0;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.o_busy, 0);
        check("rst_tx_start", bus.o_tx_start, 0);
        check("rst_tx_data", bus.o_tx_data, 0);
        check("rst_result", bus.o_result, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_timeout", bus.o_timeout, 0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame
        txq.delete();
        start_req(8'h0F, 8'h03, 6'h20, "nom");
        tx_byte(8'h0F, 0, 0, "nom_b0");
        tx_byte(8'h03, 0, 0, "nom_b1");
        tx_byte(8'h20, 1, 0, "nom_b2");
        repeat (5) @(negedge clk);
        check("nom_wait_busy", bus.o_busy, 1);
        rx_resp(8'h12, "nom");
        repeat (3) @(negedge clk);
        check("nom_tx_count", txq.size(), 3);
        check("nom_q0", txq.size() > 0 ? txq[0] : 8'hxx, 8'h0F);
        check("nom_q2", txq.size() > 2 ? txq[2] : 8'hxx, 8'h20);

        // Timeout: no response, pulse 50 cycles after the third tx_done
        start_req(8'h01, 8'h02, 6'h03, "to");
        tx_byte(8'h01, 0, 0, "to_b0");
        tx_byte(8'h02, 0, 0, "to_b1");
        tx_byte(8'h03, 1, 0, "to_b2");
        early = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (j < 50 && (bus.o_timeout || !bus.o_busy)) early = 1'b1;
        end
        check("to_early", early, 0);
        check("to_pulse", bus.o_timeout, 1);
        check("to_busy", bus.o_busy, 0);
        check("to_result_kept", bus.o_result, 8'h12);
        check("to_no_valid", bus.o_valid, 0);
        @(negedge clk);
        check("to_pulse_off", bus.o_timeout, 0);

        // Response in the last timeout cycle wins
        start_req(8'h04, 8'h05, 6'h06, "race");
        tx_byte(8'h04, 0, 0, "race_b0");
        tx_byte(8'h05, 0, 0, "race_b1");
        tx_byte(8'h06, 1, 0, "race_b2");
        repeat (49) @(negedge clk);
        check("race_still_busy", bus.o_busy, 1);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = 8'hAA;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        check("race_valid", bus.o_valid, 1);
        check("race_result", bus.o_result, 8'hAA);
        check("race_no_timeout", bus.o_timeout, 0);
        @(negedge clk);
        check("race_no_timeout2", bus.o_timeout, 0);
        check("race_idle", bus.o_busy, 0);

        // Ignored request while busy and stray rx byte during transmission
        txq.delete();
        start_req(8'h11, 8'h22, 6'h05, "ign");
        tx_byte(8'h11, 0, 1, "ign_b0");
        check("ign_stray", bus.o_result, 8'hAA);
        tx_byte(8'h22, 0, 0, "ign_b1");
        tx_byte(8'h05, 1, 0, "ign_b2");
        rx_resp(8'h77, "ign");
        repeat (20) @(negedge clk);
        check("ign_no_2nd_frame", txq.size(), 3);
        check("ign_idle", bus.o_busy, 0);

        // Asynchronous reset while waiting for byte 1 to finish
        start_req(8'hC1, 8'hC2, 6'h01, "rstm");
        tx_byte(8'hC1, 0, 0, "rstm_b0");
        repeat (3) @(negedge clk);
        check("rstm_pre_busy", bus.o_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rstm_busy", bus.o_busy, 0);
        check("rstm_tx_start", bus.o_tx_start, 0);
        check("rstm_tx_data", bus.o_tx_data, 0);
        check("rstm_result", bus.o_result, 0);
        check("rstm_valid", bus.o_valid, 0);
        check("rstm_timeout", bus.o_timeout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txq.delete();

        // Fresh frame after reset, also covering opcode padding
        start_req(8'hA5, 8'h5A, 6'h3F, "pad");
        tx_byte(8'hA5, 0, 0, "pad_b0");
        tx_byte(8'h5A, 0, 0, "pad_b1");
        tx_byte(8'h3F, 1, 0, "pad_b2");
        rx_resp(8'h3C, "pad");
        repeat (3) @(negedge clk);
        check("pad_tx_count", txq.size(), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_uart_host.md
# alu_uart_host

Byte-level host sequencer for the UART ALU link: the initiator end of the three-byte command / one-byte response protocol that the UART ALU design serves. A parallel request carrying operand A, operand B and opcode is serialised as three bytes through a UART transmitter. The block then waits for the single result byte from a UART receiver, with a response timeout. It sits between a test or controller block and the existing `Transmitter`/`Receiver` byte ports, and runs on the same clock and baud generator.

## Interface
- `RESP_TIMEOUT`, default 2_000_000: clock cycles allowed between the third `i_tx_done` and the result `i_rx_done`; must be ≥ 2.
- `i_clk`  in  1  single system clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  request strobe; sampled only in IDLE.
- `i_op_a`  in  8  operand A.
- `i_op_b`  in  8  operand B.
- `i_opcode`  in  6  ALU opcode.
- `o_busy`  out  1  high in every state except IDLE.
- `o_tx_start`  out  1  one-cycle pulse that starts one byte transmission.
- `o_tx_data`  out  8  byte to transmit; held stable from the pulse until `i_tx_done`.
- `i_tx_done`  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- `i_rx_done`  in  1  one-cycle pulse from the receiver; `i_rx_data` is valid in the same cycle.
- `i_rx_data`  in  8  received byte.
- `o_result`  out  8  last accepted ALU result; holds until the next result.
- `o_valid`  out  1  one-cycle pulse when `o_result` updates.
- `o_timeout`  out  1  one-cycle pulse on response timeout.

## Operation
- Frame order on the wire:
  - byte 0 = A;
  - byte 1 = B;
  - byte 2 = {2'b00, opcode}.
- The response is exactly one byte.
- FSM states: IDLE, START, WAIT_TX, WAIT_RX, DONE.
- IDLE:
  - `i_req`=1 latches A, B and opcode;
  - clears the byte index to 0;
  - moves to START.
- START:
  - asserts `o_tx_start` for one cycle;
  - drives `o_tx_data` with the byte selected by the index;
  - moves to WAIT_TX.
- WAIT_TX, on `i_tx_done`:
  - index < 2: increment the index and return to START;
  - index = 2: clear the timeout counter and move to WAIT_RX.
- WAIT_RX:
  - the counter increments every cycle;
  - on `i_rx_done`: capture `i_rx_data` into `o_result` and move to DONE;
  - when the counter reaches `RESP_TIMEOUT-1` with no `i_rx_done`: pulse `o_timeout`, leave `o_result` unchanged and return to IDLE.
- DONE: pulse `o_valid` and return to IDLE.
- Ignored inputs:
  - `i_req` outside IDLE, with no queueing;
  - `i_rx_done` outside WAIT_RX, including echo or garbage during transmission;
  - `i_tx_done` outside WAIT_TX.
- Simultaneous events:
  - `i_rx_done` in the final timeout cycle wins: result captured, no timeout pulse;
  - `i_req` in the same cycle that IDLE is re-entered is ignored, because it is not yet IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `o_busy`, `o_tx_start`, `o_valid` and `o_timeout` = 0;
  - `o_tx_data` and `o_result` = 8'h00;
  - index and counter = 0.
- Reset applies immediately (asynchronous), including mid-frame. A transmission already started is not aborted in the transmitter; the bench must also reset the transmitter.
- Request-to-start latency: `i_req` at edge n gives `o_tx_start` high in cycle n+1.
- Inter-byte gap: `i_tx_done` at edge m gives the next `o_tx_start` high in cycle m+1.
- Result latency: `i_rx_done` at edge k gives `o_result` updated and `o_valid` high in cycle k+1; IDLE is reached in cycle k+2.
- Timeout: `o_timeout` is high for exactly one cycle, `RESP_TIMEOUT` cycles after entry to WAIT_RX. `o_busy` falls in the same cycle.
- All outputs are registered.

## Structure
- Shared package (alu_uart_pkg):
  - state encoding;
  - frame length constant FRAME_BYTES = 3;
  - opcode width 6;
  - data width 8.
- Timeout counter width is $clog2(RESP_TIMEOUT), computed locally.
- Single module with no sub-modules. The FSM, byte mux and timeout counter all live in `alu_uart_host`.

## Test plan
- Nominal frame:
  - stimulus: `i_req` with A=8'h0F, B=8'h03, op=6'h20; tx_done model with a 10-cycle delay; rx returns 8'h12;
  - required: tx bytes 0F, 03, 20 in order; one `o_tx_start` per byte; `o_valid` pulse with `o_result`=8'h12; `o_busy` low afterwards.
- Timeout:
  - stimulus: `RESP_TIMEOUT`=50; no rx response;
  - required: `o_timeout` pulse exactly 50 cycles after the third tx_done; `o_result` keeps its prior value; returns to IDLE.
- Race at the timeout boundary:
  - stimulus: `i_rx_done` (8'hAA) in cycle 49 of 50;
  - required: `o_valid` with 8'hAA and no `o_timeout`.
- Ignored events:
  - stimulus: `i_req` while busy, and a stray `i_rx_done` (8'h55) between bytes 0 and 1;
  - required: no second frame; the stray byte is not captured; the later true result is captured.
- Reset mid-frame:
  - stimulus: assert `i_reset` while in WAIT_TX for byte 1;
  - required: all outputs reset immediately; a subsequent request sends the full 3-byte frame starting at A.
- Opcode padding:
  - stimulus: op=6'h3F;
  - required: byte 2 = 8'h3F, with the upper two bits 0.
